// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter: N valid/ready requesters share one registered downstream stage.
// An owner may keep the channel for up to MaxBurst consecutive beats before rotation.
module bus_rr_arbiter #(
  parameter int unsigned Width    = 32,
  parameter int unsigned N        = 4,
  parameter int unsigned MaxBurst = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           valid_i,
  input  logic [N*Width-1:0]     data_i,
  output logic [N-1:0]           ready_o,
  output logic                   valid_o,
  output logic [Width-1:0]       data_o,
  output logic [$clog2(N)-1:0]   grant_idx_o,
  input  logic                   ready_i
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(MaxBurst + 1);
  localparam logic [IdxW:0]   NumReq   = (IdxW+1)'(N);
  localparam logic [CntW-1:0] BurstMax = CntW'(MaxBurst);

  logic [IdxW-1:0]  ptr;
  logic [CntW-1:0]  cnt;
  logic [IdxW-1:0]  winner;
  logic [IdxW:0]    sum;
  logic             found;
  logic             lock;
  logic             space;
  logic             load;
  logic [Width-1:0] data_arr [N];

  // Unpack the flat requester data bus.
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = data_i[g*Width +: Width];
  end

  assign space = ~valid_o | ready_i;
  assign load  = space & (|valid_i);
  assign lock  = valid_i[ptr] & (cnt < BurstMax);

  // Search ptr+1 .. ptr (wrapping); the owner wins outright while locked.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    sum    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sum = {1'b0, ptr} + (IdxW+1)'(k);
      if (sum >= NumReq) sum = sum - NumReq;
      if (!found && valid_i[sum[IdxW-1:0]]) begin
        winner = sum[IdxW-1:0];
        found  = 1'b1;
      end
    end
    if (lock) winner = ptr;
  end

  always_comb begin
    ready_o = '0;
    if (!rst && load) ready_o[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o     <= 1'b0;
      data_o      <= '0;
      grant_idx_o <= '0;
      ptr         <= IdxW'(N - 1);
      cnt         <= BurstMax;
    end else if (load) begin
      valid_o     <= 1'b1;
      data_o      <= data_arr[winner];
      grant_idx_o <= winner;
      ptr         <= winner;
      cnt         <= ((winner == ptr) && (cnt < BurstMax)) ? cnt + CntW'(1) : CntW'(1);
    end else if (space) begin
      valid_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (N=4, MaxBurst=2, Width=32).
module tb_bus_rr_arbiter;

  localparam int unsigned Width = 32;
  localparam int unsigned N     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       valid_i;
  logic [N*Width-1:0] data_i;
  logic [N-1:0]       ready_o;
  logic               valid_o;
  logic [Width-1:0]   data_o;
  logic [1:0]         grant_idx_o;
  logic               ready_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] seq [N];

  bus_rr_arbiter #(.Width(32), .N(4), .MaxBurst(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .grant_idx_o(grant_idx_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_idx;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_seq_data();
    for (int i = 0; i < N; i++) data_i[i*Width +: Width] = 32'(i * 256) + 32'(seq[i]);
  endtask

  task automatic check_out(input string name, input logic ev, input logic [1:0] ei,
                           input logic [31:0] ed);
    check(name, {29'd0, valid_o, grant_idx_o, data_o}, {29'd0, ev, ei, ed});
  endtask

  initial begin
    // burst/rotation with all requesters valid
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h000};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h001};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h100};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h101};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h200};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h201};
    vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h300};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h301};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h002};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h003};
    // backpressure: hold three cycles, then resume with no gap
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h003};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h003};
    vecs[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h003};
    vecs[13] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h102};
    // idle drains valid_o but holds data/index
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h102};
    // lock release: 2 for one beat, then 3, then 1
    vecs[15] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h202};
    vecs[16] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h302};
    vecs[17] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h103};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h103};

    for (int i = 0; i < N; i++) seq[i] = 8'd0;
    rst = 1'b1;
    valid_i = 4'b1111;
    ready_i = 1'b1;
    drive_seq_data();

    // reset held with active inputs
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_out", 1'b0, 2'd0, 32'h0);
    check("reset_ready", {60'd0, ready_o}, 64'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (v != 0) @(negedge clk);
      valid_i = vecs[v].valid;
      ready_i = vecs[v].rdy;
      drive_seq_data();
      #1;
      check($sformatf("vec%0d_ready", v), {60'd0, ready_o}, {60'd0, vecs[v].exp_ready});
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d_out", v), vecs[v].exp_valid, vecs[v].exp_idx, vecs[v].exp_data);
      for (int i = 0; i < N; i++) if (vecs[v].exp_ready[i]) seq[i]++;
    end

    // sole requester streams 0xA0..0xA5 back to back
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      valid_i = 4'b0010;
      ready_i = 1'b1;
      data_i[1*Width +: Width] = 32'hA0 + 32'(k);
      #1;
      check($sformatf("sole%0d_ready", k), {60'd0, ready_o}, 64'h2);
      @(posedge clk);
      #1;
      check_out($sformatf("sole%0d_out", k), 1'b1, 2'd1, 32'hA0 + 32'(k));
    end

    // reset mid-stream while stalled
    @(negedge clk);
    valid_i = 4'b0100;
    ready_i = 1'b0;
    #1;
    check("stall_ready", {60'd0, ready_o}, 64'h0);
    #2;
    rst = 1'b1;
    #1;
    check_out("midrst_out", 1'b0, 2'd0, 32'h0);
    check("midrst_ready", {60'd0, ready_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    valid_i = 4'b1000;
    ready_i = 1'b1;
    for (int i = 0; i < N; i++) seq[i] = 8'd0;
    drive_seq_data();
    #1;
    check("post_rst_ready", {60'd0, ready_o}, 64'h8);
    @(posedge clk);
    #1;
    check_out("post_rst_out", 1'b1, 2'd3, 32'h300);

    // fresh cnt=1: owner 3 keeps one more beat against requester 0
    @(negedge clk);
    seq[3] = 8'd1;
    valid_i = 4'b1001;
    drive_seq_data();
    #1;
    check("fresh_cnt_ready", {60'd0, ready_o}, 64'h8);
    @(posedge clk);
    #1;
    check_out("fresh_cnt_out", 1'b1, 2'd3, 32'h301);

    // burst used up: rotation to 0
    @(negedge clk);
    seq[3] = 8'd2;
    drive_seq_data();
    #1;
    check("rotate_ready", {60'd0, ready_o}, 64'h1);
    @(posedge clk);
    #1;
    check_out("rotate_out", 1'b1, 2'd0, 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
